// File: rtl/drive_sequencer.sv
// -----------------------------------------------------------------------------
// drive_sequencer
//   Top-level drive controller for the line-following car. It sequences the car
//   through idle, line follow, obstacle hold and lost-line search, and produces
//   the registered dir/speed pair for the Motor block.
//   - An obstacle stops the car at once. Restart needs a sustained run of clear
//     sonar samples, which gives hysteresis.
//   - Speed soft-starts by ramping between the motor deadband floor and the
//     switch-selected target. The ramp also works downward.
//
// Ports
//   clk       in   1  system clock (100 MHz)
//   rst       in   1  synchronous reset, active low
//   en        in   1  run enable; 0 forces IDLE
//   sw_speed  in   2  target select: [1] -> 870, else [0] -> 840, else 780
//   track_l   in   1  left IR sensor, 0 = on line
//   track_c   in   1  centre IR sensor, 0 = on line
//   track_r   in   1  right IR sensor, 0 = on line
//   distance  in   8  sonar distance in cm
//   dir       out  2  0=BACKWARD 1=LEFT 2=RIGHT 3=FORWARD
//   speed     out 10  PWM duty, 0..1023
//   state_o   out  2  current state (debug/LED)
//
// State table
//   state      | meaning
//   IDLE    (0)| stopped, waiting for enable; dir FORWARD, speed 0
//   FOLLOW  (1)| following the line; dir tracks steer, speed ramps to target
//   BLOCKED (2)| obstacle hold; speed 0, dir keeps last steer
//   LOST    (3)| all sensors white; creep at MIN_SPEED on the frozen last turn
// -----------------------------------------------------------------------------
module drive_sequencer #(
    parameter int unsigned RAMP_DIV   = 100_000,
    parameter logic [9:0]  RAMP_STEP  = 10'd10,
    parameter logic [9:0]  MIN_SPEED  = 10'd600,
    parameter logic [7:0]  STOP_DIST  = 8'd24,
    parameter logic [7:0]  CLEAR_DIST = 8'd30,
    parameter int unsigned CLEAR_CYC  = 50_000_000,
    parameter int unsigned LOST_CYC   = 20_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] sw_speed,
    input  logic       track_l,
    input  logic       track_c,
    input  logic       track_r,
    input  logic [7:0] distance,
    output logic [1:0] dir,
    output logic [9:0] speed,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FOLLOW  = 2'd1,
        ST_BLOCKED = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd2;
    localparam logic [1:0] DIR_FWD   = 2'd3;

    localparam logic [9:0] TGT_HI  = 10'd870;
    localparam logic [9:0] TGT_MID = 10'd840;
    localparam logic [9:0] TGT_LO  = 10'd780;

    // The +1 keeps every counter at least one bit wide, even for a limit of 1.
    localparam int RAMP_W  = $clog2(RAMP_DIV + 1);
    localparam int CLEAR_W = $clog2(CLEAR_CYC + 1);
    localparam int LOST_W  = $clog2(LOST_CYC + 1);

    localparam logic [RAMP_W-1:0]  RAMP_LAST  = RAMP_W'(RAMP_DIV - 1);
    localparam logic [CLEAR_W-1:0] CLEAR_LAST = CLEAR_W'(CLEAR_CYC - 1);
    localparam logic [LOST_W-1:0]  LOST_LAST  = LOST_W'(LOST_CYC - 1);
    localparam logic [RAMP_W-1:0]  RAMP_ONE   = RAMP_W'(1);
    localparam logic [CLEAR_W-1:0] CLEAR_ONE  = CLEAR_W'(1);
    localparam logic [LOST_W-1:0]  LOST_ONE   = LOST_W'(1);

    state_t             state_q;
    logic [1:0]         steer_q;
    logic [1:0]         dir_q;
    logic [9:0]         speed_q;
    logic [RAMP_W-1:0]  ramp_cnt_q;
    logic [CLEAR_W-1:0] clear_cnt_q;
    logic [LOST_W-1:0]  lost_cnt_q;

    logic [1:0]  steer_d;
    logic [9:0]  target;
    logic [9:0]  speed_ramp;
    logic [10:0] sum_up;
    logic [10:0] diff_dn;
    logic        obstacle;
    logic        clear_smp;
    logic        all_white;

    assign obstacle  = (distance <= STOP_DIST);
    assign clear_smp = (distance >= CLEAR_DIST);
    assign all_white = track_l & track_c & track_r;

    always_comb begin
        if (sw_speed[1]) begin
            target = TGT_HI;
        end else if (sw_speed[0]) begin
            target = TGT_MID;
        end else begin
            target = TGT_LO;
        end
    end

    // Steering: each heading has its own priority order for which sensor it
    // reacts to first.
    always_comb begin
        steer_d = steer_q;
        case (steer_q)
            DIR_LEFT: begin
                if (!track_c) begin
                    steer_d = DIR_FWD;
                end else if (!track_r) begin
                    steer_d = DIR_RIGHT;
                end
            end
            DIR_RIGHT: begin
                if (!track_c) begin
                    steer_d = DIR_FWD;
                end else if (!track_l) begin
                    steer_d = DIR_LEFT;
                end
            end
            default: begin
                if (!track_l) begin
                    steer_d = DIR_LEFT;
                end else if (!track_r) begin
                    steer_d = DIR_RIGHT;
                end
            end
        endcase
    end

    // One ramp step toward the target. The sums are 11 bits wide so that a
    // step can neither wrap past 1023 nor go below 0. The result is clamped
    // to the target so the speed never overshoots it.
    always_comb begin
        sum_up     = {1'b0, speed_q} + {1'b0, RAMP_STEP};
        diff_dn    = {1'b0, speed_q} - {1'b0, RAMP_STEP};
        speed_ramp = speed_q;
        if (speed_q < target) begin
            speed_ramp = (sum_up >= {1'b0, target}) ? target : sum_up[9:0];
        end else if (speed_q > target) begin
            speed_ramp = (diff_dn[10] || (diff_dn[9:0] <= target)) ? target : diff_dn[9:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            state_q     <= ST_IDLE;
            steer_q     <= DIR_FWD;
            dir_q       <= DIR_FWD;
            speed_q     <= 10'd0;
            ramp_cnt_q  <= '0;
            clear_cnt_q <= '0;
            lost_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_FOLLOW;
                    speed_q    <= MIN_SPEED;
                    dir_q      <= steer_q;
                    ramp_cnt_q <= '0;
                    lost_cnt_q <= '0;
                end
                ST_FOLLOW: begin
                    if (obstacle) begin
                        state_q     <= ST_BLOCKED;
                        speed_q     <= 10'd0;
                        ramp_cnt_q  <= '0;
                        lost_cnt_q  <= '0;
                        clear_cnt_q <= '0;
                    end else if (all_white && (lost_cnt_q == LOST_LAST)) begin
                        state_q    <= ST_LOST;
                        speed_q    <= MIN_SPEED;
                        dir_q      <= steer_q;
                        ramp_cnt_q <= '0;
                        lost_cnt_q <= '0;
                    end else begin
                        steer_q    <= steer_d;
                        dir_q      <= steer_d;
                        lost_cnt_q <= all_white ? (lost_cnt_q + LOST_ONE) : '0;
                        if (ramp_cnt_q == RAMP_LAST) begin
                            ramp_cnt_q <= '0;
                            speed_q    <= speed_ramp;
                        end else begin
                            ramp_cnt_q <= ramp_cnt_q + RAMP_ONE;
                        end
                    end
                end
                ST_BLOCKED: begin
                    // Any sample short of CLEAR_DIST restarts the clearance run,
                    // including the band between the stop and clear thresholds.
                    if (!clear_smp) begin
                        clear_cnt_q <= '0;
                    end else if (clear_cnt_q == CLEAR_LAST) begin
                        state_q     <= ST_FOLLOW;
                        speed_q     <= MIN_SPEED;
                        dir_q       <= steer_q;
                        clear_cnt_q <= '0;
                        ramp_cnt_q  <= '0;
                        lost_cnt_q  <= '0;
                    end else begin
                        clear_cnt_q <= clear_cnt_q + CLEAR_ONE;
                    end
                end
                ST_LOST: begin
                    if (obstacle) begin
                        state_q     <= ST_BLOCKED;
                        speed_q     <= 10'd0;
                        clear_cnt_q <= '0;
                    end else if (!all_white) begin
                        // Line reacquired: steering resumes on the same edge
                        // that leaves LOST.
                        state_q    <= ST_FOLLOW;
                        steer_q    <= steer_d;
                        dir_q      <= steer_d;
                        ramp_cnt_q <= '0;
                        lost_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dir     = dir_q;
    assign speed   = speed_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_drive_sequencer.sv
module tb_drive_sequencer;

    localparam int RAMP_DIV  = 4;
    localparam int CLEAR_CYC = 8;
    localparam int LOST_CYC  = 16;
    localparam int MIN_SPD   = 600;
    localparam int STEP      = 10;

    localparam int S_IDLE = 0, S_FOLLOW = 1, S_BLOCKED = 2, S_LOST = 3;
    localparam int D_LEFT = 1, D_RIGHT = 2, D_FWD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] sw_speed = 2'b00;
    logic       track_l = 1'b1;
    logic       track_c = 1'b1;
    logic       track_r = 1'b1;
    logic [7:0] distance = 8'd100;
    logic [1:0] dir;
    logic [9:0] speed;
    logic [1:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_state, m_steer, m_dir, m_speed;
    int m_age;      // FOLLOW cycles since the last entry into FOLLOW
    int m_white;    // length of the current all-white run seen in FOLLOW
    int m_clear;    // length of the current clear-distance run seen in BLOCKED

    drive_sequencer #(
        .RAMP_DIV   (RAMP_DIV),
        .RAMP_STEP  (10'd10),
        .MIN_SPEED  (10'd600),
        .STOP_DIST  (8'd24),
        .CLEAR_DIST (8'd30),
        .CLEAR_CYC  (CLEAR_CYC),
        .LOST_CYC   (LOST_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sw_speed (sw_speed),
        .track_l  (track_l),
        .track_c  (track_c),
        .track_r  (track_r),
        .distance (distance),
        .dir      (dir),
        .speed    (speed),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int target_of(input logic [1:0] sw);
        if (sw[1]) return 870;
        if (sw[0]) return 840;
        return 780;
    endfunction

    // New heading from the current heading and what the sensors see.
    function automatic int steer_after(input int cur, input bit l, input bit c, input bit r);
        if (cur == D_FWD) return !l ? D_LEFT : (!r ? D_RIGHT : D_FWD);
        if (cur == D_LEFT) return !c ? D_FWD : (!r ? D_RIGHT : D_LEFT);
        return !c ? D_FWD : (!l ? D_LEFT : D_RIGHT);
    endfunction

    task automatic model_home();
        m_state = S_IDLE; m_steer = D_FWD; m_dir = D_FWD; m_speed = 0;
        m_age = 0; m_white = 0; m_clear = 0;
    endtask

    task automatic model_enter_follow(input int spd);
        m_state = S_FOLLOW; m_speed = spd; m_dir = m_steer;
        m_age = 0; m_white = 0; m_clear = 0;
    endtask

    task automatic model_step();
        bit white, obst, clr;
        int t;
        white = track_l && track_c && track_r;
        obst  = (distance <= 24);
        clr   = (distance >= 30);
        t     = target_of(sw_speed);
        if (!rst || !en) begin
            model_home();
        end else begin
            case (m_state)
                S_IDLE: model_enter_follow(MIN_SPD);
                S_FOLLOW: begin
                    if (obst) begin
                        m_state = S_BLOCKED; m_speed = 0; m_clear = 0;
                    end else if (white && (m_white + 1 == LOST_CYC)) begin
                        m_state = S_LOST; m_speed = MIN_SPD; m_dir = m_steer; m_white = 0;
                    end else begin
                        m_steer = steer_after(m_steer, track_l, track_c, track_r);
                        m_dir   = m_steer;
                        m_white = white ? m_white + 1 : 0;
                        m_age++;
                        if (m_age % RAMP_DIV == 0) begin
                            if (m_speed < t) m_speed = (m_speed + STEP > t) ? t : m_speed + STEP;
                            else if (m_speed > t) m_speed = (m_speed - STEP < t) ? t : m_speed - STEP;
                        end
                    end
                end
                S_BLOCKED: begin
                    if (clr) begin
                        m_clear++;
                        if (m_clear == CLEAR_CYC) model_enter_follow(MIN_SPD);
                    end else begin
                        m_clear = 0;
                    end
                end
                default: begin
                    if (obst) begin
                        m_state = S_BLOCKED; m_speed = 0; m_clear = 0;
                    end else if (!white) begin
                        m_steer = steer_after(m_steer, track_l, track_c, track_r);
                        model_enter_follow(m_speed);
                    end
                end
            endcase
        end
    endtask

    // One clock: advance the model on the edge, compare just after it.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("dir", 16'(dir), 16'(m_dir));
        check("speed", 16'(speed), 16'(m_speed));
        check("state", 16'(state_o), 16'(m_state));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_track(input logic [2:0] t);
        {track_l, track_c, track_r} = t;
    endtask

    initial begin
        model_home();

        // 1. reset
        rst = 1'b0; en = 1'b0;
        steps(3);
        rst = 1'b1;
        step();
        check("rst_dir", 16'(dir), 16'd3);
        check("rst_speed", 16'(speed), 16'd0);
        check("rst_state", 16'(state_o), 16'd0);

        // 2. start and ramp to 870
        en = 1'b1; sw_speed = 2'b10; distance = 8'd100; set_track(3'b101);
        step();
        check("start_state", 16'(state_o), 16'd1);
        check("start_speed", 16'(speed), 16'd600);
        steps(27 * RAMP_DIV);
        check("ramp_top", 16'(speed), 16'd870);
        steps(3 * RAMP_DIV);
        check("ramp_hold", 16'(speed), 16'd870);

        // 3. steering
        set_track(3'b001); step();
        check("steer_left", 16'(dir), 16'd1);
        set_track(3'b101); step();
        check("steer_fwd", 16'(dir), 16'd3);
        set_track(3'b110); step();
        check("steer_right", 16'(dir), 16'd2);

        // 4. obstacle and clearance hysteresis
        distance = 8'd24; step();
        check("block_speed", 16'(speed), 16'd0);
        check("block_state", 16'(state_o), 16'd2);
        distance = 8'd30; steps(5);
        distance = 8'd27; steps(1);
        distance = 8'd30; steps(CLEAR_CYC - 1);
        check("clear_wait", 16'(state_o), 16'd2);
        step();
        check("resume_state", 16'(state_o), 16'd1);
        check("resume_speed", 16'(speed), 16'd600);

        // 5. lost line
        set_track(3'b111); steps(LOST_CYC - 1);
        check("lost_wait", 16'(state_o), 16'd1);
        step();
        check("lost_state", 16'(state_o), 16'd3);
        check("lost_speed", 16'(speed), 16'd600);
        check("lost_dir", 16'(dir), 16'd2);
        set_track(3'b101); step();
        check("refind_state", 16'(state_o), 16'd1);

        // 6. enable drop mid-ramp, simultaneous enable and obstacle, reset while blocked
        steps(10 * RAMP_DIV);
        check("ramp_700", 16'(speed), 16'd700);
        en = 1'b0; step();
        check("dis_state", 16'(state_o), 16'd0);
        check("dis_speed", 16'(speed), 16'd0);
        en = 1'b1; distance = 8'd20; step();
        check("en_obst_first", 16'(state_o), 16'd1);
        step();
        check("en_obst_second", 16'(state_o), 16'd2);
        rst = 1'b0; step();
        check("mid_rst_state", 16'(state_o), 16'd0);
        check("mid_rst_dir", 16'(dir), 16'd3);
        check("mid_rst_speed", 16'(speed), 16'd0);
        rst = 1'b1; distance = 8'd100;

        // randomized segments checked against the model
        for (int seg = 0; seg < 140; seg++) begin
            int len;
            len = $urandom_range(1, 24);
            if ($urandom_range(0, 2) == 0) set_track(3'b111);
            else set_track(3'($urandom_range(0, 7)));
            case ($urandom_range(0, 7))
                0:       distance = 8'($urandom_range(0, 40));
                1:       distance = 8'($urandom_range(22, 32));
                2:       distance = 8'($urandom_range(30, 255));
                default: distance = 8'd100;
            endcase
            if ($urandom_range(0, 3) == 0) sw_speed = 2'($urandom_range(0, 3));
            en  = ($urandom_range(0, 30) != 0);
            rst = ($urandom_range(0, 60) != 0);
            steps(len);
            rst = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
